// File: rtl/datapath_seq_pkg.sv
// Shared encodings for the self-sequencing datapath: ALU ops, shifter ops,
// writeback sources, FSM states and status-flag bit positions.
package datapath_seq_pkg;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_AND  = 2'b10;
   localparam logic [1:0] ALU_NOTB = 2'b11;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL  = 2'b01;
   localparam logic [1:0] SH_LSR  = 2'b10;
   localparam logic [1:0] SH_ASR  = 2'b11;

   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_IMM   = 2'b01;
   localparam logic [1:0] VSEL_MDATA = 2'b10;
   localparam logic [1:0] VSEL_PC    = 2'b11;

   // status = {N,V,Z}
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RDA  = 3'd1,
      ST_RDB  = 3'd2,
      ST_EXEC = 3'd3,
      ST_WB   = 3'd4
   } state_t;

endpackage

// File: rtl/datapath_seq_regfile.sv
// NREGS x WIDTH register file: one async read port, one sync write port, sync clear.
// DATAPATH_SEQ_DBG_EN adds a second async read port for debug inspection.
module dp_regfile
#(
   parameter int WIDTH = 16,
   parameter int NREGS = 8,
   localparam int RW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_we,
   input  logic [RW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [RW-1:0]    i_raddr,
`ifdef DATAPATH_SEQ_DBG_EN
   input  logic [RW-1:0]    i_dbg_num,
   output logic [WIDTH-1:0] o_dbg_data,
`endif
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [NREGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

`ifdef DATAPATH_SEQ_DBG_EN
   assign o_dbg_data = r_mem[i_dbg_num];
`endif

endmodule

// File: rtl/datapath_seq.sv
// Self-sequencing datapath: accepts one op descriptor, then walks it through
// RDA -> RDB -> EXEC -> WB. Optional debug read port under DATAPATH_SEQ_DBG_EN.
module datapath_seq
   import datapath_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREGS = 8,
   parameter int PC_W  = 8,
   localparam int RW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   // Handshake: a descriptor is taken on a rising edge where op_valid && op_ready.
   // op_ready is high only in IDLE; op_valid outside IDLE is ignored, not queued.
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [RW-1:0]    op_rn,
   input  logic [RW-1:0]    op_rm,
   input  logic [RW-1:0]    op_rd,
   input  logic [1:0]       op_shift,
   input  logic [1:0]       op_aluop,
   input  logic             op_asel,
   input  logic             op_bsel,
   input  logic [WIDTH-1:0] op_imm,
   input  logic [1:0]       op_vsel,
   input  logic             op_wb,
   input  logic [WIDTH-1:0] mdata,
   input  logic [PC_W-1:0]  pc,
`ifdef DATAPATH_SEQ_DBG_EN
   input  logic [RW-1:0]    dbg_num,
   output logic [WIDTH-1:0] dbg_data,
`endif
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       status
);

   state_t r_state;
   state_t w_next_state;

   logic [RW-1:0]    r_rn;
   logic [RW-1:0]    r_rm;
   logic [RW-1:0]    r_rd;
   logic [1:0]       r_shift;
   logic [1:0]       r_aluop;
   logic             r_asel;
   logic             r_bsel;
   logic [WIDTH-1:0] r_imm;
   logic [1:0]       r_vsel;
   logic             r_wb;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_c;
   logic [2:0]       r_status;

   logic             w_accept;
   logic             w_rf_we;
   logic [RW-1:0]    w_rf_raddr;
   logic [WIDTH-1:0] w_rf_rdata;
   logic [WIDTH-1:0] w_rf_wdata;
   logic [WIDTH-1:0] w_shift_out;
   logic [WIDTH-1:0] w_ain;
   logic [WIDTH-1:0] w_bin;
   logic [WIDTH-1:0] w_alu;
   logic             w_v;
   logic [2:0]       w_flags;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next_state = ST_RDA;
         ST_RDA:  w_next_state = ST_RDB;
         ST_RDB:  w_next_state = ST_EXEC;
         ST_EXEC: w_next_state = ST_WB;
         ST_WB:   w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      op_ready   = 1'b0;
      done       = 1'b0;
      w_rf_we    = 1'b0;
      w_rf_raddr = r_rm;
      case (r_state)
         ST_IDLE: op_ready = 1'b1;
         ST_RDA:  w_rf_raddr = r_rn;
         ST_WB: begin
            done    = 1'b1;
            w_rf_we = r_wb;
         end
         default: ;
      endcase
   end

   assign w_accept = op_valid & op_ready;

   // ---------------- Descriptor latch and A/B/C/status registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rn     <= '0;
         r_rm     <= '0;
         r_rd     <= '0;
         r_shift  <= SH_NONE;
         r_aluop  <= ALU_ADD;
         r_asel   <= 1'b0;
         r_bsel   <= 1'b0;
         r_imm    <= '0;
         r_vsel   <= VSEL_C;
         r_wb     <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_c      <= '0;
         r_status <= '0;
      end else begin
         if (w_accept) begin
            r_rn    <= op_rn;
            r_rm    <= op_rm;
            r_rd    <= op_rd;
            r_shift <= op_shift;
            r_aluop <= op_aluop;
            r_asel  <= op_asel;
            r_bsel  <= op_bsel;
            r_imm   <= op_imm;
            r_vsel  <= op_vsel;
            r_wb    <= op_wb;
         end
         case (r_state)
            ST_RDA:  r_a <= w_rf_rdata;
            ST_RDB:  r_b <= w_rf_rdata;
            ST_EXEC: begin
               r_c      <= w_alu;
               r_status <= w_flags;
            end
            default: ;
         endcase
      end
   end

   // ---------------- Shifter (by one) ----------------
   always_comb begin
      w_shift_out = r_b;
      case (r_shift)
         SH_NONE: w_shift_out = r_b;
         SH_LSL:  w_shift_out = {r_b[WIDTH-2:0], 1'b0};
         SH_LSR:  w_shift_out = {1'b0, r_b[WIDTH-1:1]};
         SH_ASR:  w_shift_out = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
         default: w_shift_out = r_b;
      endcase
   end

   assign w_ain = r_asel ? '0 : r_a;
   assign w_bin = r_bsel ? r_imm : w_shift_out;

   // ---------------- ALU and flags ----------------
   // Overflow: operands that should agree in sign (ADD) or disagree (SUB) yet flip the result sign.
   always_comb begin
      w_alu = '0;
      w_v   = 1'b0;
      case (r_aluop)
         ALU_ADD: begin
            w_alu = w_ain + w_bin;
            w_v   = (w_ain[WIDTH-1] == w_bin[WIDTH-1]) && (w_alu[WIDTH-1] != w_ain[WIDTH-1]);
         end
         ALU_SUB: begin
            w_alu = w_ain - w_bin;
            w_v   = (w_ain[WIDTH-1] != w_bin[WIDTH-1]) && (w_alu[WIDTH-1] != w_ain[WIDTH-1]);
         end
         ALU_AND:  w_alu = w_ain & w_bin;
         ALU_NOTB: w_alu = ~w_bin;
         default: ;
      endcase
   end

   always_comb begin
      w_flags         = '0;
      w_flags[FLAG_N] = w_alu[WIDTH-1];
      w_flags[FLAG_V] = w_v;
      w_flags[FLAG_Z] = (w_alu == '0);
   end

   // ---------------- Writeback source ----------------
   always_comb begin
      w_rf_wdata = r_c;
      case (r_vsel)
         VSEL_C:     w_rf_wdata = r_c;
         VSEL_IMM:   w_rf_wdata = r_imm;
         VSEL_MDATA: w_rf_wdata = mdata;
         VSEL_PC:    w_rf_wdata = WIDTH'(pc);
         default:    w_rf_wdata = r_c;
      endcase
   end

   dp_regfile #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) u_regfile (
      .clk        (clk),
      .reset      (reset),
      .i_we       (w_rf_we),
      .i_waddr    (r_rd),
      .i_wdata    (w_rf_wdata),
      .i_raddr    (w_rf_raddr),
`ifdef DATAPATH_SEQ_DBG_EN
      .i_dbg_num  (dbg_num),
      .o_dbg_data (dbg_data),
`endif
      .o_rdata    (w_rf_rdata)
   );

   assign result = r_c;
   assign status = r_status;

endmodule

// File: tb/tb_datapath_seq.sv
// Scoreboard bench for datapath_seq (WIDTH=16, NREGS=8): directed descriptors,
// expected {status,result} queued at issue and checked by a done-triggered monitor.
module tb_datapath_seq;
   import datapath_seq_pkg::*;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          op_valid;
   logic          op_ready;
   logic [2:0]    op_rn, op_rm, op_rd;
   logic [1:0]    op_shift, op_aluop, op_vsel;
   logic          op_asel, op_bsel, op_wb;
   logic [W-1:0]  op_imm;
   logic [W-1:0]  mdata;
   logic [7:0]    pc;
   logic          done;
   logic [W-1:0]  result;
   logic [2:0]    status;
`ifdef DATAPATH_SEQ_DBG_EN
   logic [2:0]    dbg_num;
   logic [W-1:0]  dbg_data;
`endif

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [W+2:0] exp_q[$];
   int           acc_q[$];

   datapath_seq #(.WIDTH(16), .NREGS(8), .PC_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op_rn    (op_rn),
      .op_rm    (op_rm),
      .op_rd    (op_rd),
      .op_shift (op_shift),
      .op_aluop (op_aluop),
      .op_asel  (op_asel),
      .op_bsel  (op_bsel),
      .op_imm   (op_imm),
      .op_vsel  (op_vsel),
      .op_wb    (op_wb),
      .mdata    (mdata),
      .pc       (pc),
`ifdef DATAPATH_SEQ_DBG_EN
      .dbg_num  (dbg_num),
      .dbg_data (dbg_data),
`endif
      .done     (done),
      .result   (result),
      .status   (status)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (done) begin
         logic [W+2:0] e;
         int a;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending op", cyc);
         end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            checks++;
            if ({status, result} !== e) begin
               errors++;
               $display("FAIL result_status: got status=%03b result=%04h, required status=%03b result=%04h",
                        status, result, e[W+2:W], e[W-1:0]);
            end
            checks++;
            if (cyc - a != 4) begin
               errors++;
               $display("FAIL latency: done %0d cycles after accept, required 4", cyc - a);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic set_fields(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                             input logic [1:0] sh, input logic [1:0] alu, input logic asel,
                             input logic bsel, input logic [W-1:0] imm, input logic [1:0] vsel,
                             input logic wb);
      op_rn = rn; op_rm = rm; op_rd = rd; op_shift = sh; op_aluop = alu;
      op_asel = asel; op_bsel = bsel; op_imm = imm; op_vsel = vsel; op_wb = wb;
   endtask

   task automatic issue(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                        input logic [1:0] sh, input logic [1:0] alu, input logic asel,
                        input logic bsel, input logic [W-1:0] imm, input logic [1:0] vsel,
                        input logic wb, input logic [W-1:0] md, input logic [7:0] pcv,
                        input bit push, input logic [W-1:0] exp_res, input logic [2:0] exp_st);
      int n = 0;
      @(negedge clk);
      while (!op_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!op_ready) begin
         errors++;
         $display("FAIL issue_wait: op_ready=%0b after %0d cycles, required 1", op_ready, n);
      end
      set_fields(rn, rm, rd, sh, alu, asel, bsel, imm, vsel, wb);
      mdata    = md;
      pc       = pcv;
      op_valid = 1'b1;
      if (push) begin
         exp_q.push_back({exp_st, exp_res});
         acc_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      op_valid = 1'b0;
   endtask

   // Write an immediate through the ALU path: C = 0 + imm, R[rd] = imm.
   task automatic wr_imm(input logic [2:0] rd, input logic [W-1:0] v, input logic [2:0] st);
      issue(3'd0, 3'd0, rd, SH_NONE, ALU_ADD, 1'b1, 1'b1, v, VSEL_IMM, 1'b1, 16'h0, 8'h0, 1'b1, v, st);
   endtask

   // Read a register back: C = R[r] + 0, no writeback.
   task automatic rd_reg(input logic [2:0] r, input logic [W-1:0] v, input logic [2:0] st);
      issue(r, 3'd0, 3'd0, SH_NONE, ALU_ADD, 1'b0, 1'b1, 16'h0, VSEL_C, 1'b0, 16'h0, 8'h0, 1'b1, v, st);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset    = 1'b1;
      op_valid = 1'b0;
      set_fields(3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, 1'b0);
      mdata = 16'h0;
      pc    = 8'h0;
`ifdef DATAPATH_SEQ_DBG_EN
      dbg_num = 3'd0;
`endif
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // 1. reset state
      @(negedge clk);
      check_val("reset_result", result, 16'h0);
      check_val("reset_status", {13'h0, status}, 16'h0);
      check_val("reset_op_ready", {15'h0, op_ready}, 16'h1);
      check_val("reset_done", {15'h0, done}, 16'h0);
`ifdef DATAPATH_SEQ_DBG_EN
      for (int i = 0; i < 8; i++) begin
         dbg_num = 3'(i);
         #1 check_val("reset_dbg_reg", dbg_data, 16'h0);
      end
`endif
      for (int i = 0; i < 8; i++) rd_reg(3'(i), 16'h0, 3'b001);

      // 2. immediate writeback
      wr_imm(3'd3, 16'h0007, 3'b000);
      rd_reg(3'd3, 16'h0007, 3'b000);
`ifdef DATAPATH_SEQ_DBG_EN
      dbg_num = 3'd3;
      #1 check_val("dbg_r3", dbg_data, 16'h0007);
`endif

      // 3. ADD overflow
      wr_imm(3'd0, 16'h7FFF, 3'b000);
      wr_imm(3'd1, 16'h0001, 3'b000);
      issue(3'd0, 3'd1, 3'd2, SH_NONE, ALU_ADD, 1'b0, 1'b0, 16'h0, VSEL_C, 1'b1, 16'h0, 8'h0, 1'b1, 16'h8000, 3'b110);
      rd_reg(3'd2, 16'h8000, 3'b100);

      // 4. SUB to zero with lsl, then asr / lsr on 8000
      wr_imm(3'd4, 16'h0008, 3'b000);
      wr_imm(3'd5, 16'h0004, 3'b000);
      issue(3'd4, 3'd5, 3'd7, SH_LSL, ALU_SUB, 1'b0, 1'b0, 16'h0, VSEL_C, 1'b1, 16'h0, 8'h0, 1'b1, 16'h0000, 3'b001);
      rd_reg(3'd7, 16'h0000, 3'b001);
      issue(3'd0, 3'd2, 3'd6, SH_ASR, ALU_ADD, 1'b1, 1'b0, 16'h0, VSEL_C, 1'b1, 16'h0, 8'h0, 1'b1, 16'hC000, 3'b100);
      rd_reg(3'd6, 16'hC000, 3'b100);
      issue(3'd0, 3'd2, 3'd0, SH_LSR, ALU_ADD, 1'b1, 1'b0, 16'h0, VSEL_C, 1'b0, 16'h0, 8'h0, 1'b1, 16'h4000, 3'b000);

      // SUB overflow, AND, NOT
      issue(3'd2, 3'd1, 3'd0, SH_NONE, ALU_SUB, 1'b0, 1'b0, 16'h0, VSEL_C, 1'b0, 16'h0, 8'h0, 1'b1, 16'h7FFF, 3'b010);
      issue(3'd0, 3'd2, 3'd0, SH_NONE, ALU_AND, 1'b0, 1'b0, 16'h0, VSEL_C, 1'b0, 16'h0, 8'h0, 1'b1, 16'h0000, 3'b001);
      issue(3'd0, 3'd0, 3'd0, SH_NONE, ALU_NOTB, 1'b0, 1'b1, 16'h0, VSEL_C, 1'b0, 16'h0, 8'h0, 1'b1, 16'hFFFF, 3'b100);

      // mdata and pc writeback sources
      issue(3'd0, 3'd0, 3'd5, SH_NONE, ALU_ADD, 1'b1, 1'b1, 16'h0001, VSEL_MDATA, 1'b1, 16'hABCD, 8'h00, 1'b1, 16'h0001, 3'b000);
      rd_reg(3'd5, 16'hABCD, 3'b100);
      issue(3'd0, 3'd0, 3'd4, SH_NONE, ALU_ADD, 1'b1, 1'b1, 16'h0001, VSEL_PC, 1'b1, 16'h0000, 8'h5A, 1'b1, 16'h0001, 3'b000);
      rd_reg(3'd4, 16'h005A, 3'b000);

      // wb=0 leaves R3 alone; rn==rm==rd
      issue(3'd0, 3'd0, 3'd3, SH_NONE, ALU_ADD, 1'b1, 1'b1, 16'h1111, VSEL_IMM, 1'b0, 16'h0, 8'h0, 1'b1, 16'h1111, 3'b000);
      rd_reg(3'd3, 16'h0007, 3'b000);
      issue(3'd3, 3'd3, 3'd3, SH_NONE, ALU_ADD, 1'b0, 1'b0, 16'h0, VSEL_C, 1'b1, 16'h0, 8'h0, 1'b1, 16'h000E, 3'b000);
      rd_reg(3'd3, 16'h000E, 3'b000);

      // 5. op_valid held high with changing fields; only the latched op runs
      wr_imm(3'd1, 16'h0055, 3'b000);
      for (int k = 1; k <= 4; k++) begin
         set_fields(3'(k), 3'(k), 3'd1, 2'(k), ALU_NOTB, 1'b1, 1'b1, 16'hFF00 | 16'(k), VSEL_IMM, 1'b1);
         op_valid = 1'b1;
         @(negedge clk);
         check_val("busy_op_ready", {15'h0, op_ready}, 16'h0);
         @(posedge clk);
         #1;
      end
      set_fields(3'd1, 3'd0, 3'd0, SH_NONE, ALU_ADD, 1'b0, 1'b1, 16'h0, VSEL_C, 1'b0);
      op_valid = 1'b1;
      @(negedge clk);
      check_val("reaccept_op_ready", {15'h0, op_ready}, 16'h1);
      exp_q.push_back({3'b000, 16'h0055});
      acc_q.push_back(cyc);
      @(posedge clk);
      #1 op_valid = 1'b0;

      // 6. reset during EXEC: no write, no done
      issue(3'd0, 3'd0, 3'd6, SH_NONE, ALU_ADD, 1'b1, 1'b1, 16'h1234, VSEL_IMM, 1'b1, 16'h0, 8'h0, 1'b0, 16'h0, 3'b000);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_val("exec_done", {15'h0, done}, 16'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_val("post_reset_op_ready", {15'h0, op_ready}, 16'h1);
      check_val("post_reset_done", {15'h0, done}, 16'h0);
      check_val("post_reset_result", result, 16'h0);
      check_val("post_reset_status", {13'h0, status}, 16'h0);
      rd_reg(3'd6, 16'h0000, 3'b001);
      rd_reg(3'd3, 16'h0000, 3'b001);

      // drain
      for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
      repeat (2) @(negedge clk);
      check_val("drain_pending", 16'(exp_q.size()), 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
